jk_vector_counter: RTL

- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit bank of JK cells sharing one clock and one reset.
- A mode input selects between bitwise JK operation and synchronous modulo-MODULUS up-count, down-count or parallel load.
- Used as a general-purpose state register and counter in lab datapaths.
- Provides complementary outputs, a terminal-count flag and a registered wrap pulse.

---
 rtl/jk_vector_counter_if.sv | 26 ++
 rtl/jk_vector_counter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/jk_vector_counter_if.sv
// Bus bundle for jk_vector_counter.
// The controller drives the enable, mode and data fields.
// The counter returns its state, the complement, terminal count and wrap pulse.
interface jk_vector_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, j, k, d,
        input  q, qbar, tc, wrap
    );

    modport slave (
        input  en, mode, j, k, d,
        output q, qbar, tc, wrap
    );
endinterface

// File: rtl/jk_vector_counter.sv
// jk_vector_counter: a WIDTH-bit bank of JK cells that can also act as a
// modulo-MODULUS up/down counter with parallel load.
// Modes: 00 bitwise JK, 01 count up, 10 count down, 11 load (clamped).
// Bitwise JK mode is deliberately not range-limited. The counting modes
// recover any out-of-range value by wrapping.

// Next-state function of one JK cell.
module jk_vector_cell (
    input  logic q,
    input  logic j,
    input  logic k,
    output logic nxt
);
    // JK truth table: hold, clear, set, toggle.
    always_comb begin
        nxt = q;
        case ({j, k})
            2'b00:   nxt = q;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            default: nxt = ~q;
        endcase
    end
endmodule

module jk_vector_counter #(
    parameter int              WIDTH       = 8,
    parameter longint unsigned MODULUS     = 256,
    parameter longint unsigned RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    jk_vector_counter_if.slave    bus
);
    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_UP = 2'b01;
    localparam logic [1:0] MODE_DN = 2'b10;
    localparam logic [1:0] MODE_LD = 2'b11;

    // The modulus is carried in WIDTH+1 bits so that MODULUS == 2^WIDTH
    // fits and every range compare is a plain unsigned compare.
    localparam logic [WIDTH:0]   MOD_W = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   TOP_W = MOD_W - 1'b1;
    localparam logic [WIDTH-1:0] MAXV  = TOP_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

    // Illegal parameter sets are rejected at elaboration.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("jk_vector_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
        $error("jk_vector_counter: MODULUS must be 2..2^WIDTH");
    end
    if (RESET_VALUE >= MODULUS) begin : g_bad_rst
        $error("jk_vector_counter: RESET_VALUE must be < MODULUS");
    end

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic [WIDTH-1:0] jk_nxt;
    logic [WIDTH-1:0] j_in;
    logic [WIDTH-1:0] k_in;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic             up_wrap;
    logic             dn_wrap;
    logic             d_ok;

    assign j_in  = bus.j;
    assign k_in  = bus.k;
    assign q_ext = {1'b0, q_r};
    assign d_ext = {1'b0, bus.d};

    // One JK cell per bit lane.
    jk_vector_cell u_cell [WIDTH-1:0] (
        .q   (q_r),
        .j   (j_in),
        .k   (k_in),
        .nxt (jk_nxt)
    );

    // Wrap and clamp conditions. Out-of-range values count as wrapping
    // in both directions, so the counter always returns to 0..MODULUS-1.
    assign up_wrap = (q_ext >= TOP_W);
    assign dn_wrap = (q_r == '0) || (q_ext >= MOD_W);
    assign d_ok    = (d_ext < MOD_W);

    // Next state. The register holds, and the wrap pulse drops, unless en is high.
    always_comb begin
        q_nxt    = q_r;
        wrap_nxt = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                MODE_JK: q_nxt = jk_nxt;
                MODE_UP: begin
                    q_nxt    = up_wrap ? '0 : q_r + WIDTH'(1'b1);
                    wrap_nxt = up_wrap;
                end
                MODE_DN: begin
                    q_nxt    = dn_wrap ? MAXV : q_r - WIDTH'(1'b1);
                    wrap_nxt = dn_wrap;
                end
                default: q_nxt = d_ok ? bus.d : MAXV;
            endcase
        end
    end

    // State register. The synchronous reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r    <= RST_V;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            wrap_r <= wrap_nxt;
        end
    end

    // Outputs. tc is combinational from q and mode and does not depend on en.
    always_comb begin
        bus.q    = q_r;
        bus.qbar = ~q_r;
        bus.wrap = wrap_r;
        bus.tc   = ((bus.mode == MODE_UP) && (q_r == MAXV)) ||
                   ((bus.mode == MODE_DN) && (q_r == '0));
    end
endmodule
